bits_frame: RTL and testbench
=============================

# bits_frame

Frame builder between the binary-clock time counter and the WS2812 serial driver. On each time update it snapshots the four BCD digits (hours tens/units, minutes tens/units) into a 16-pixel on/off mask. It then streams one 24-bit GRB word per pixel to the driver over a valid/ready handshake, and holds off new frames for the WS2812 latch gap.

## Interface
- `MAIN_CLK`, 12000000: CLK frequency in Hz; sizes the latch gap.
- `RESET_US`, 80: WS2812 latch (line-low) time in µs.
- `CLK` in 1: main clock.
- `RST` in 1: one clock; reset is synchronous and active-high.
- `DH1` in 2: hours tens digit.
- `DH0` in 4: hours units digit.
- `DM1` in 3: minutes tens digit.
- `DM0` in 4: minutes units digit.
- `UPDATE` in 1: single-cycle pulse meaning the digits have changed and are stable.
- `BRIGHT` in 2: brightness level, 0 (dimmest) to 3 (full).
- `PIX_READY` in 1: driver accepts the current pixel.
- `PIX_DATA` out 24: GRB colour word for the current pixel.
- `PIX_VALID` out 1: `PIX_DATA` holds a valid pixel.
- `BUSY` out 1: a frame is being sent, or the latch gap is running.

## Operation
- **States:** IDLE, SEND, GAP.
- **IDLE → SEND:** when `UPDATE` is high or `pending` is set.
  - Capture `DH1`, `DH0`, `DM1`, `DM0` (zero-extended to 4 bits) and `BRIGHT` into the snapshot.
  - Clear `pending`; set pixel index `p` = 0.
- **Pixel mapping:** column `c = p[3:2]`, where c=0 is DH1, 1 is DH0, 2 is DM1, 3 is DM0.
  - Even columns: bit `p[1:0]`.
  - Odd columns (serpentine wiring): bit `3 - p[1:0]`.
  - Digit values above 9 are not checked; their raw bits are shown.
- **Colour:**
  - Lit pixel: `HOUR_COLOUR` for c=0–1, `MIN_COLOUR` for c=2–3.
  - Each 8-bit channel is independently right-shifted by `3 - BRIGHT`.
  - Unlit pixel: 24'h000000.
- **SEND:**
  - Hold `PIX_VALID` high.
  - On `PIX_VALID && PIX_READY`, increment `p`.
  - The handshake on p=15 moves to GAP with gap counter = `LATCH_CYCLES`.
- **GAP:** decrement the counter each cycle. When it reaches 1, go to IDLE.
- **`UPDATE` during SEND or GAP:**
  - Sets `pending`; multiple pulses collapse into one.
  - The current frame is never altered, since the snapshot is frozen.
  - The next frame starts on the first IDLE cycle.
- **`UPDATE` coinciding with the IDLE→SEND cycle:** consumed by that frame; `pending` stays 0.
- **Reset:**
  - State = IDLE, `pending` = 1, `p` = 0, outputs cleared.
  - A frame of the current digits is therefore sent right after reset is released.
  - Reset mid-frame aborts immediately; the driver shares `RST`.

## Timing
- **Reset values:** `PIX_VALID` = 0, `PIX_DATA` = 24'h000000, `BUSY` = 0.
- **Registered outputs:** `PIX_DATA`, `PIX_VALID` and `BUSY` are all registered.
- **Latency:** `UPDATE` sampled in IDLE at edge N gives `PIX_VALID`/`BUSY` = 1 after edge N+1 ("cycle N+1").
- **Data stability:** `PIX_DATA` is stable while `PIX_VALID && !PIX_READY`. After a handshake, the next pixel is presented on the following cycle.
- **Throughput:** with `PIX_READY` held high, one pixel per cycle. Pixels occupy cycles N+1 to N+16.
- **End of frame:** `PIX_VALID` drops the cycle after the pixel-15 handshake. `BUSY` stays high for `LATCH_CYCLES` further cycles.
- **Gap length:** `LATCH_CYCLES = max(1, MAIN_CLK/1_000_000 * RESET_US)`, in integer arithmetic. The counter width is `$clog2(LATCH_CYCLES+1)`.

## Structure
- **Package `bits_pkg`:**
  - `NUM_PIXELS` = 16.
  - `HOUR_COLOUR` = 24'h00FF00 (red, GRB).
  - `MIN_COLOUR` = 24'hFF0000 (green, GRB).
  - State enum.
  - Function `pix_bit(p)` returning the column and bit index.
- **Sub-module `bits_pixel_map`:** combinational; maps the snapshot mask, `p` and brightness to a 24-bit word. The parent registers its output.
- **Instantiation:** the parent instantiates the existing WS2812 driver downstream.

## Test plan
- **Digits 1,2,3,4, `UPDATE`, `BRIGHT`=3, `PIX_READY`=1:**
  - Lit pixels are exactly p0, p6, p8, p9, p13.
  - p0 and p6 = 24'h00FF00; p8, p9, p13 = 24'hFF0000; all others 0.
  - 16 consecutive valid cycles starting at N+1.
- **Same frame with `BRIGHT`=1:** lit hour pixels = 24'h003F00, lit minute pixels = 24'h3F0000.
- **`PIX_READY` toggled 0/1 every cycle:** each `PIX_DATA` stays stable while stalled, and the frame takes 32 cycles with the same pixel sequence.
- **Three `UPDATE` pulses mid-SEND with digits changed to 0,0,0,0:**
  - Exactly one further frame, all 16 pixels 0.
  - It starts 1 cycle after GAP ends.
- **`MAIN_CLK`=2, `RESET_US`=0:** `LATCH_CYCLES` = 1, so `BUSY` falls 1 cycle after the last pixel.
- **`RST` asserted at p=7:**
  - Next cycle: `PIX_VALID` = 0, `BUSY` = 0.
  - After release, a full frame starts from p0 with no `UPDATE`.

Source files
------------

// File: rtl/bits_pkg.sv
// Shared types and constants for the binary-clock frame builder.
package bits_pkg;

  localparam int unsigned NUM_PIXELS = 16;
  localparam int unsigned PIX_W      = 24;
  localparam int unsigned IDX_W      = 4;

  localparam logic [PIX_W-1:0] HOUR_COLOUR = 24'h00FF00;
  localparam logic [PIX_W-1:0] MIN_COLOUR  = 24'hFF0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Frozen copy of the digits and brightness for one frame
  typedef struct packed {
    logic [3:0] dm0;
    logic [3:0] dm1;
    logic [3:0] dh0;
    logic [3:0] dh1;
    logic [1:0] bright;
  } snap_t;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] bit_idx;
  } pix_pos_t;

  // Odd columns are wired serpentine, so their bit order is reversed
  function automatic pix_pos_t pix_bit(input logic [IDX_W-1:0] p);
    pix_pos_t r;
    r.col     = p[3:2];
    r.bit_idx = p[2] ? 2'(2'd3 - p[1:0]) : p[1:0];
    return r;
  endfunction

endpackage

// File: rtl/bits_pixel_map.sv
// Combinational pixel-index to GRB colour mapping with brightness scaling.
module bits_pixel_map
  import bits_pkg::*;
(
  input  logic [NUM_PIXELS-1:0] mask,
  input  logic [IDX_W-1:0]      idx,
  input  logic [1:0]            bright,
  output logic [PIX_W-1:0]      pix_c
);

  pix_pos_t         pos;
  logic             lit;
  logic [PIX_W-1:0] colour;
  logic [1:0]       shamt;

  always_comb begin
    pos    = pix_bit(idx);
    lit    = mask[{pos.col, pos.bit_idx}];
    colour = pos.col[1] ? MIN_COLOUR : HOUR_COLOUR;
    shamt  = ~bright;
    pix_c  = '0;
    if (lit) begin
      pix_c = {colour[23:16] >> shamt, colour[15:8] >> shamt, colour[7:0] >> shamt};
    end
  end

endmodule

// File: rtl/bits_frame.sv
// Snapshots BCD digits on update and streams 16 GRB pixels to the WS2812 driver.
module bits_frame
  import bits_pkg::*;
#(
  parameter int unsigned MAIN_CLK = 12000000,
  parameter int unsigned RESET_US = 80
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       DH1,
  input  logic [3:0]       DH0,
  input  logic [2:0]       DM1,
  input  logic [3:0]       DM0,
  input  logic             UPDATE,
  input  logic [1:0]       BRIGHT,
  input  logic             PIX_READY,
  output logic [PIX_W-1:0] PIX_DATA,
  output logic             PIX_VALID,
  output logic             BUSY
);

  localparam int unsigned RAW_CYCLES   = (MAIN_CLK / 1000000) * RESET_US;
  localparam int unsigned LATCH_CYCLES = (RAW_CYCLES < 1) ? 1 : RAW_CYCLES;
  localparam int unsigned CNT_W        = $clog2(LATCH_CYCLES + 1);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(LATCH_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_PIX = IDX_W'(NUM_PIXELS - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] p, p_n;
  logic             pending, pending_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  snap_t            snap, snap_n;
  logic [PIX_W-1:0] pix_data_n;
  logic             pix_valid_n;
  logic             busy_n;

  logic [IDX_W-1:0] map_idx;
  logic [PIX_W-1:0] map_pix_c;
  logic             hs;

  // First load presents p; after a handshake the following pixel is loaded
  assign map_idx = PIX_VALID ? IDX_W'(p + 1'b1) : p;
  assign hs      = PIX_VALID && PIX_READY;

  bits_pixel_map u_map (
    .mask   ({snap.dm0, snap.dm1, snap.dh0, snap.dh1}),
    .idx    (map_idx),
    .bright (snap.bright),
    .pix_c  (map_pix_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      p         <= '0;
      pending   <= 1'b1;
      cnt       <= '0;
      snap      <= '0;
      PIX_DATA  <= '0;
      PIX_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_n;
      p         <= p_n;
      pending   <= pending_n;
      cnt       <= cnt_n;
      snap      <= snap_n;
      PIX_DATA  <= pix_data_n;
      PIX_VALID <= pix_valid_n;
      BUSY      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    p_n         = p;
    pending_n   = pending;
    cnt_n       = cnt;
    snap_n      = snap;
    pix_data_n  = PIX_DATA;
    pix_valid_n = PIX_VALID;

    unique case (state)
      IDLE: begin
        if (UPDATE || pending) begin
          state_n   = SEND;
          snap_n    = '{dm0: DM0, dm1: 4'(DM1), dh0: DH0, dh1: 4'(DH1), bright: BRIGHT};
          pending_n = 1'b0;
          p_n       = '0;
        end
      end
      SEND: begin
        if (UPDATE) pending_n = 1'b1;
        if (!PIX_VALID) begin
          pix_data_n  = map_pix_c;
          pix_valid_n = 1'b1;
        end else if (hs) begin
          if (p == LAST_PIX) begin
            pix_data_n  = '0;
            pix_valid_n = 1'b0;
            cnt_n       = GAP_LOAD;
            state_n     = GAP;
          end else begin
            p_n        = IDX_W'(p + 1'b1);
            pix_data_n = map_pix_c;
          end
        end
      end
      GAP: begin
        if (UPDATE) pending_n = 1'b1;
        cnt_n = CNT_W'(cnt - 1'b1);
        if (cnt <= GAP_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // BUSY rises one cycle after frame start and covers exactly the gap cycles
    busy_n = (state == SEND) || (state_n == GAP);
  end

endmodule

// File: tb/tb_bits_frame.sv
// Directed bench for bits_frame: pixel tables, stalls, pending updates, gap and reset.
module tb_bits_frame;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  DH1 = '0;
  logic [3:0]  DH0 = '0;
  logic [2:0]  DM1 = '0;
  logic [3:0]  DM0 = '0;
  logic        UPDATE = 1'b0;
  logic [1:0]  BRIGHT = '0;
  logic        PIX_READY = 1'b1;
  logic        rdy_s = 1'b1;
  logic [23:0] PIX_DATA, pix_data_s;
  logic        PIX_VALID, pix_valid_s;
  logic        BUSY, busy_s;

  always #5 CLK = ~CLK;

  bits_frame dut (
    .CLK(CLK), .RST(RST), .DH1(DH1), .DH0(DH0), .DM1(DM1), .DM0(DM0),
    .UPDATE(UPDATE), .BRIGHT(BRIGHT), .PIX_READY(PIX_READY),
    .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .BUSY(BUSY)
  );

  bits_frame #(.MAIN_CLK(2), .RESET_US(0)) dut_s (
    .CLK(CLK), .RST(RST), .DH1(DH1), .DH0(DH0), .DM1(DM1), .DM0(DM0),
    .UPDATE(UPDATE), .BRIGHT(BRIGHT), .PIX_READY(rdy_s),
    .PIX_DATA(pix_data_s), .PIX_VALID(pix_valid_s), .BUSY(busy_s)
  );

  typedef struct {
    logic [1:0]  dh1;
    logic [3:0]  dh0;
    logic [2:0]  dm1;
    logic [3:0]  dm0;
    logic [1:0]  bright;
    logic        toggle;
    logic [15:0] lit;
    logic [23:0] hour;
    logic [23:0] mins;
  } vec_t;

  vec_t vecs[6];
  vec_t zero_vec;
  int   total = 0;
  int   bad = 0;
  bit   small_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_pix(input vec_t v, input int k);
    if (!v.lit[k]) return 24'h000000;
    return (k < 8) ? v.hour : v.mins;
  endfunction

  task automatic apply(input vec_t v);
    DH1 = v.dh1; DH0 = v.dh0; DM1 = v.dm1; DM0 = v.dm0; BRIGHT = v.bright;
  endtask

  // Called in the cycle ending at the IDLE->SEND edge; checks every pixel cycle.
  task automatic stream(input vec_t v, input bit upd_mid, input int rst_at);
    int k, cyc;
    bit done;
    @(posedge CLK); #1;
    UPDATE = 1'b0;
    check("valid_before_latency", 32'(PIX_VALID), 32'd0);
    k = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 64) begin
      @(posedge CLK); #1;
      cyc++;
      PIX_READY = v.toggle ? (cyc % 2 == 0) : 1'b1;
      if (upd_mid) begin
        if (cyc == 3) begin
          DH1 = '0; DH0 = '0; DM1 = '0; DM0 = '0; BRIGHT = '0;
        end
        UPDATE = (cyc == 3 || cyc == 5 || cyc == 7);
      end
      if (rst_at != 0 && cyc == rst_at) begin
        check("pix_before_rst", 32'(PIX_DATA), 32'(exp_pix(v, k)));
        RST = 1'b1;
        @(posedge CLK); #1;
        check("rst_valid", 32'(PIX_VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        RST = 1'b0;
        return;
      end
      check("valid", 32'(PIX_VALID), 32'd1);
      check("busy", 32'(BUSY), 32'd1);
      check($sformatf("pix%0d", k), 32'(PIX_DATA), 32'(exp_pix(v, k)));
      if (PIX_READY && PIX_VALID) begin
        k++;
        if (k == 16) done = 1'b1;
      end
    end
    UPDATE = 1'b0;
    check("frame_cycles", 32'(cyc), v.toggle ? 32'd32 : 32'd16);
    PIX_READY = 1'b1;
  endtask

  // Counts cycles with BUSY high and no valid pixel; returns in the first idle cycle.
  task automatic gap(input int exp_len);
    int n;
    bit fin;
    n = 0; fin = 1'b0;
    while (!fin && n < 2000) begin
      @(posedge CLK); #1;
      if (BUSY && !PIX_VALID) n++;
      else fin = 1'b1;
    end
    check("gap_len", 32'(n), 32'(exp_len));
    check("idle_busy", 32'(BUSY), 32'd0);
    check("idle_valid", 32'(PIX_VALID), 32'd0);
  endtask

  // Short-gap instance: post-reset frame of 16 pixels followed by a 1-cycle gap.
  initial begin
    int nv, ng, cyc;
    bit fin;
    nv = 0; ng = 0; cyc = 0; fin = 1'b0;
    wait (RST == 1'b0);
    while (!fin && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
      if (pix_valid_s) nv++;
      else if (nv > 0 && busy_s) ng++;
      else if (nv > 0) fin = 1'b1;
    end
    check("small_pixels", 32'(nv), 32'd16);
    check("small_gap", 32'(ng), 32'd1);
    small_done = 1'b1;
  end

  initial begin
    vecs[0] = '{2'd1, 4'd2, 3'd3, 4'd4, 2'd3, 1'b0, 16'h2341, 24'h00FF00, 24'hFF0000};
    vecs[1] = '{2'd1, 4'd2, 3'd3, 4'd4, 2'd1, 1'b0, 16'h2341, 24'h003F00, 24'h3F0000};
    vecs[2] = '{2'd2, 4'd3, 3'd5, 4'd9, 2'd2, 1'b0, 16'h95C2, 24'h007F00, 24'h7F0000};
    vecs[3] = '{2'd0, 4'd0, 3'd0, 4'd0, 2'd0, 1'b0, 16'h0000, 24'h001F00, 24'h1F0000};
    vecs[4] = '{2'd3, 4'd15, 3'd7, 4'd15, 2'd0, 1'b0, 16'hF7F3, 24'h001F00, 24'h1F0000};
    vecs[5] = '{2'd1, 4'd2, 3'd3, 4'd4, 2'd3, 1'b1, 16'h2341, 24'h00FF00, 24'hFF0000};
    zero_vec = vecs[3];

    // Reset state, then the automatic post-reset frame
    apply(vecs[0]);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_pix_valid", 32'(PIX_VALID), 32'd0);
    check("rst_pix_data", 32'(PIX_DATA), 32'd0);
    check("rst_busy_out", 32'(BUSY), 32'd0);
    RST = 1'b0;
    stream(vecs[0], 1'b0, 0);
    gap(960);

    for (int i = 0; i < 6; i++) begin
      apply(vecs[i]);
      UPDATE = 1'b1;
      stream(vecs[i], 1'b0, 0);
      gap(960);
    end

    // Three updates mid-frame collapse into exactly one zero frame after the gap
    apply(vecs[0]);
    UPDATE = 1'b1;
    stream(vecs[0], 1'b1, 0);
    gap(960);
    stream(zero_vec, 1'b0, 0);
    gap(960);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check("no_extra_busy", 32'(BUSY), 32'd0);
      check("no_extra_valid", 32'(PIX_VALID), 32'd0);
    end

    // Reset while pixel 7 is presented; a full frame follows without UPDATE
    apply(vecs[0]);
    UPDATE = 1'b1;
    stream(vecs[0], 1'b0, 8);
    stream(vecs[0], 1'b0, 0);
    gap(960);

    for (int i = 0; i < 10 && !small_done; i++) @(posedge CLK);
    check("small_monitor_done", 32'(small_done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
